// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg : default raster timing constants and counter width
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int POS_W = 9;

  localparam int H_DISPLAY_DEF = 256;
  localparam int H_FRONT_DEF   = 7;
  localparam int H_SYNC_DEF    = 23;
  localparam int H_BACK_DEF    = 23;

  localparam int V_DISPLAY_DEF = 240;
  localparam int V_BOTTOM_DEF  = 14;
  localparam int V_SYNC_DEF    = 3;
  localparam int V_TOP_DEF     = 5;

  function automatic int axis_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_generator_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter : enabled up-counter that returns to zero after MAX
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrap_counter #(
  parameter int MAX = 308,
  parameter int W   = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // wrap is a pure decode of the count so a cascaded stage can gate on it
  assign wrap = (count == MAX_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator : beam counters with zero-latency sync/visible decodes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_BOTTOM  = V_BOTTOM_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_TOP     = V_TOP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             display_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
  localparam int H_MAX   = H_TOTAL - 1;
  localparam int V_MAX   = V_TOTAL - 1;

  localparam logic [POS_W-1:0] H_DISP_P   = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_DISP_P   = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] HS_FIRST_P = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_LAST_P  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST_P = POS_W'(V_DISPLAY + V_BOTTOM);
  localparam logic [POS_W-1:0] VS_LAST_P  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  // Totals that do not fit the position width would silently alias
  generate
    if (H_TOTAL > (1 << POS_W)) begin : g_h_range_check
      $error("vga_sync_generator: horizontal total %0d exceeds %0d-bit range", H_TOTAL, POS_W);
    end
    if (V_TOTAL > (1 << POS_W)) begin : g_v_range_check
      $error("vga_sync_generator: vertical total %0d exceeds %0d-bit range", V_TOTAL, POS_W);
    end
  endgenerate

  logic h_wrap;
  logic v_wrap;
  logic v_en;

  assign v_en = ce & h_wrap;

  wrap_counter #(.MAX(H_MAX), .W(POS_W)) u_h_counter (
    .clk   (clk),
    .reset (reset),
    .en    (ce),
    .count (hpos),
    .wrap  (h_wrap)
  );

  wrap_counter #(.MAX(V_MAX), .W(POS_W)) u_v_counter (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .count (vpos),
    .wrap  (v_wrap)
  );

  assign display_on  = (hpos < H_DISP_P) && (vpos < V_DISP_P);
  assign hsync       = (hpos >= HS_FIRST_P) && (hpos <= HS_LAST_P);
  assign vsync       = (vpos >= VS_FIRST_P) && (vpos <= VS_LAST_P);
  assign line_start  = (hpos == '0);
  assign frame_start = line_start && (vpos == '0);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_generator : directed checks of the default 309x262 raster
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int eh = 0;
  int ev = 0;

  vga_sync_generator dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // One clock: the reference position advances on enabled edges only
  task automatic tick();
    @(posedge clk);
    if (ce && !reset) begin
      if (eh == 308) begin
        eh = 0;
        ev = (ev == 261) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
    end
    #1;
  endtask

  function automatic logic [22:0] exp_vec();
    logic [8:0] h9;
    logic [8:0] v9;
    h9 = eh[8:0];
    v9 = ev[8:0];
    return {h9, v9, (eh < 256) && (ev < 240), (eh >= 263) && (eh <= 285),
            (ev >= 254) && (ev <= 256), eh == 0, (eh == 0) && (ev == 0)};
  endfunction

  function automatic logic [22:0] act_vec();
    return {hpos, vpos, display_on, hsync, vsync, line_start, frame_start};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b1;
    eh    = 0;
    ev    = 0;
    repeat (3) tick();
    n_tests++; if (hpos !== 9'd0)     begin n_fail++; $display("FAIL reset_hpos got %0d want 0", hpos); end
    n_tests++; if (vpos !== 9'd0)     begin n_fail++; $display("FAIL reset_vpos got %0d want 0", vpos); end
    n_tests++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL reset_display_on got %b want 1", display_on); end
    n_tests++; if (hsync !== 1'b0)    begin n_fail++; $display("FAIL reset_hsync got %b want 0", hsync); end
    n_tests++; if (vsync !== 1'b0)    begin n_fail++; $display("FAIL reset_vsync got %b want 0", vsync); end
    n_tests++; if (line_start !== 1'b1)  begin n_fail++; $display("FAIL reset_line_start got %b want 1", line_start); end
    n_tests++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL reset_frame_start got %b want 1", frame_start); end
    reset = 1'b0;
    tick();
    n_tests++; if (hpos !== 9'd1) begin n_fail++; $display("FAIL first_ce_hpos got %0d want 1", hpos); end
  endtask

  task automatic test_line_wrap();
    int errs = 0;
    int ls_cnt = 0;
    int hs_cnt = 0;
    logic d255 = 1'b0;
    logic d256 = 1'b1;
    logic [3:0] hs_edges = 4'b0000;
    for (int i = 2; i <= 309; i++) begin
      tick();
      if (act_vec() !== exp_vec()) errs++;
      if (line_start) ls_cnt++;
      if (hsync) hs_cnt++;
      if (eh == 255) d255 = display_on;
      if (eh == 256) d256 = display_on;
      if (eh == 262) hs_edges[3] = hsync;
      if (eh == 263) hs_edges[2] = hsync;
      if (eh == 285) hs_edges[1] = hsync;
      if (eh == 286) hs_edges[0] = hsync;
    end
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL line_model got %0d bad cycles want 0", errs); end
    n_tests++; if (hpos !== 9'd0) begin n_fail++; $display("FAIL line_wrap_hpos got %0d want 0", hpos); end
    n_tests++; if (vpos !== 9'd1) begin n_fail++; $display("FAIL line_wrap_vpos got %0d want 1", vpos); end
    n_tests++; if (ls_cnt !== 1) begin n_fail++; $display("FAIL line_start_count got %0d want 1", ls_cnt); end
    n_tests++; if (hs_cnt !== 23) begin n_fail++; $display("FAIL hsync_width got %0d want 23", hs_cnt); end
    n_tests++; if (hs_edges !== 4'b0110) begin n_fail++; $display("FAIL hsync_edges got %b want 0110", hs_edges); end
    n_tests++; if ({d255, d256} !== 2'b10) begin n_fail++; $display("FAIL display_edge got %b want 10", {d255, d256}); end
  endtask

  task automatic test_async_reset();
    while (eh != 100) tick();
    #2;
    reset = 1'b1;
    #1;
    eh = 0;
    ev = 0;
    n_tests++;
    if (act_vec() !== {9'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL async_reset_outputs got %h want %h", act_vec(), {9'd0, 9'd0, 5'b10011});
    end
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if (hpos !== 9'd1) begin n_fail++; $display("FAIL post_reset_hpos got %0d want 1", hpos); end
    n_tests++; if (vpos !== 9'd0) begin n_fail++; $display("FAIL post_reset_vpos got %0d want 0", vpos); end
  endtask

  task automatic test_frame_wrap();
    int errs = 0;
    int cnt = 1;
    int vs_cnt = 0;
    int vs_first = -1;
    int vs_last = -1;
    int max_v = 0;
    logic corner = 1'b0;
    while (cnt < 81000) begin
      tick();
      cnt++;
      if (act_vec() !== exp_vec()) errs++;
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(vpos);
        vs_last = int'(vpos);
      end
      if (int'(vpos) > max_v) max_v = int'(vpos);
      if (hpos == 9'd308 && vpos == 9'd261) corner = 1'b1;
      if (frame_start) break;
    end
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL frame_model got %0d bad cycles want 0", errs); end
    n_tests++; if (cnt !== 80958) begin n_fail++; $display("FAIL frame_period got %0d want 80958", cnt); end
    n_tests++; if ({hpos, vpos} !== 18'd0) begin n_fail++; $display("FAIL frame_wrap_pos got %0d,%0d want 0,0", hpos, vpos); end
    n_tests++; if (corner !== 1'b1) begin n_fail++; $display("FAIL frame_corner got %b want 1", corner); end
    n_tests++; if (max_v !== 261) begin n_fail++; $display("FAIL vpos_max got %0d want 261", max_v); end
    n_tests++; if (vs_cnt !== 927) begin n_fail++; $display("FAIL vsync_cycles got %0d want 927", vs_cnt); end
    n_tests++; if (vs_first !== 254 || vs_last !== 256) begin
      n_fail++; $display("FAIL vsync_lines got %0d..%0d want 254..256", vs_first, vs_last);
    end
  endtask

  task automatic test_clock_enable();
    int errs = 0;
    int hold_errs = 0;
    int w1 = -1;
    int w2 = -1;
    logic [22:0] prev;
    for (int i = 0; i < 1300; i++) begin
      ce   = (i % 2 == 0);
      prev = act_vec();
      tick();
      if (act_vec() !== exp_vec()) errs++;
      if (!ce && act_vec() !== prev) hold_errs++;
      if (prev[22:14] == 9'd308 && hpos == 9'd0) begin
        if (w1 < 0) w1 = i;
        else if (w2 < 0) w2 = i;
      end
    end
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL ce_model got %0d bad cycles want 0", errs); end
    n_tests++; if (hold_errs !== 0) begin n_fail++; $display("FAIL ce_hold got %0d changes want 0", hold_errs); end
    n_tests++; if (w1 !== 616) begin n_fail++; $display("FAIL ce_first_wrap got %0d want 616", w1); end
    n_tests++; if (w2 - w1 !== 618) begin n_fail++; $display("FAIL ce_line_period got %0d want 618", w2 - w1); end
    n_tests++; if (vpos !== 9'd2) begin n_fail++; $display("FAIL ce_vpos got %0d want 2", vpos); end
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b0;
    test_reset();
    test_line_wrap();
    test_async_reset();
    test_frame_wrap();
    test_clock_enable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
